ex_div: RTL and testbench

EX_DIV -- requirements
Module: ex_div

---
 rtl/ex_div_pkg.sv | 22 ++
 rtl/ex_div.sv | 103 ++++++++++
 tb/tb_ex_div.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_div_pkg.sv
// Shared EX-stage types for the iterative divider: word types, divider states, defaults.
package ex_div_pkg;

  typedef logic [31:0] Word_t;
  typedef logic        Bit_t;

  localparam Word_t       ZERO_WORD          = 32'h0000_0000;
  localparam int unsigned DIV_CYCLES_DEFAULT = 32;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_ZERO,
    DIV_ON,
    DIV_END
  } Div_state_t;

  // Magnitude of a word: two's-complement absolute value when sgn is set, raw otherwise.
  function automatic Word_t abs_word(input Word_t w, input Bit_t sgn);
    return (sgn && w[31]) ? Word_t'(~w + 32'd1) : w;
  endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, quotient to LO, remainder to HI.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  logic  signed_div,
  input  Word_t dividend,
  input  Word_t divisor,
  input  logic  cancel,
  output Word_t result_lo,
  output Word_t result_hi,
  output logic  ready,
  output logic  stall_req
);

  localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  Div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [64:0]      wreg;   // [64:32] partial remainder, [31:0] dividend shifting out / quotient shifting in
  Word_t            dvs;
  logic             neg_q;
  logic             neg_r;

  logic [33:0]      rem_sh;
  logic             rem_ge;
  logic [32:0]      rem_nxt;
  logic [64:0]      wreg_step;

  // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
  assign rem_sh    = {wreg[64:32], wreg[31]};
  assign rem_ge    = rem_sh >= {2'b00, dvs};
  assign rem_nxt   = rem_ge ? 33'(rem_sh - {2'b00, dvs}) : rem_sh[32:0];
  assign wreg_step = {rem_nxt, wreg[30:0], rem_ge};

  assign stall_req = start & ~ready & ~cancel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DIV_IDLE;
      cnt       <= '0;
      wreg      <= '0;
      dvs       <= ZERO_WORD;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      result_lo <= ZERO_WORD;
      result_hi <= ZERO_WORD;
      ready     <= 1'b0;
    end else if (cancel) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          cnt <= '0;
          if (start) begin
            if (divisor == ZERO_WORD) begin
              // Zeroed working state makes the END fix-up yield 0/0.
              state <= DIV_ZERO;
              wreg  <= '0;
              dvs   <= ZERO_WORD;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              state <= DIV_ON;
              wreg  <= {33'd0, abs_word(dividend, signed_div)};
              dvs   <= abs_word(divisor, signed_div);
              neg_q <= signed_div & (dividend[31] ^ divisor[31]);
              neg_r <= signed_div & dividend[31];
            end
          end
        end
        DIV_ZERO: state <= DIV_END;
        DIV_ON: begin
          wreg <= wreg_step;
          if (cnt == CNT_LAST) begin
            state <= DIV_END;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DIV_END: begin
          if (!start) begin
            state <= DIV_IDLE;
            ready <= 1'b0;
          end else if (!ready) begin
            result_lo <= neg_q ? Word_t'(~wreg[31:0] + 32'd1) : wreg[31:0];
            result_hi <= neg_r ? Word_t'(~wreg[63:32] + 32'd1) : wreg[63:32];
            ready     <= 1'b1;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: directed corner cases plus randomized DIV/DIVU against an arithmetic model.
module tb_ex_div;
  import ex_div_pkg::*;

  localparam int unsigned DC = 32;

  logic  clk = 1'b0;
  logic  rst, start, signed_div, cancel;
  Word_t dividend, divisor, result_lo, result_hi;
  logic  ready, stall_req;

  always #5 clk = ~clk;

  ex_div #(.DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signed_div),
    .dividend  (dividend),
    .divisor   (divisor),
    .cancel    (cancel),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .ready     (ready),
    .stall_req (stall_req)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    Word_t       lo;
    Word_t       hi;
    int unsigned rdy_cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference: plain integer division, truncating toward zero; zero divisor gives 0/0.
  function automatic void model(input logic sd, input Word_t a, input Word_t b,
                                output Word_t q, output Word_t r);
    longint sa, sb_;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else if (sd) begin
      sa  = longint'(signed'(a));
      sb_ = longint'(signed'(b));
      q   = Word_t'(sa / sb_);
      r   = Word_t'(sa % sb_);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Monitor: score each ready rise, and check results stay put while ready is held.
  logic  ready_q = 1'b0;
  Word_t last_lo, last_hi;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && ready && !ready_q) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_ready");
      end else begin
        e = sb.pop_front();
        chk("quotient", result_lo, e.lo);
        chk("remainder", result_hi, e.hi);
        chk("ready_latency", cyc, e.rdy_cyc);
      end
    end else if (!rst && ready && ready_q) begin
      chk("hold_lo", result_lo, last_lo);
      chk("hold_hi", result_hi, last_hi);
    end
    ready_q <= ready;
    last_lo <= result_lo;
    last_hi <= result_hi;
  end

  // Issue one divide from a negedge; optionally hit reset while the result is held.
  task automatic run_div(input logic sd, input Word_t a, input Word_t b,
                         input int hold, input bit rst_in_end);
    Word_t q, r;
    exp_t  e;
    int    n;
    model(sd, a, b, q, r);
    signed_div = sd;
    dividend   = a;
    divisor    = b;
    cancel     = 1'b0;
    start      = 1'b1;
    e.lo       = q;
    e.hi       = r;
    e.rdy_cyc  = cyc + 1 + ((b == 32'd0) ? 2 : DC + 1);
    sb.push_back(e);
    @(negedge clk);
    dividend   = $urandom;
    divisor    = $urandom;
    signed_div = 1'($urandom_range(0, 1));
    n = 0;
    while (!ready && n < 200) begin
      chk("stall_busy", 32'(stall_req), 32'd1);
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      fail_now("ready_timeout");
      if (sb.size() > 0) void'(sb.pop_front());
    end
    chk("stall_at_ready", 32'(stall_req), 32'd0);
    if (rst_in_end) begin
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_lo", result_lo, 32'd0);
      chk("rst_hi", result_hi, 32'd0);
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
    end else begin
      repeat (hold) @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("ready_drop", 32'(ready), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    Word_t a, b;
    int    cls;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; signed_div = 1'b0;
    dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_lo", result_lo, 32'd0);
    chk("reset_hi", result_hi, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_stall", 32'(stall_req), 32'd0);

    run_div(1'b0, 32'd7, 32'd2, 1, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 2, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_div(1'b0, 32'd5, 32'd0, 1, 1'b0);

    // Cancel at iteration 10, then confirm the block is idle and usable.
    signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    repeat (11) @(negedge clk);
    cancel = 1'b1;
    #1 chk("cancel_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    #1;
    chk("cancel_ready", 32'(ready), 32'd0);
    chk("cancel_idle_stall", 32'(stall_req), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("cancel_no_result", 32'(ready), 32'd0);
    end
    run_div(1'b0, 32'd100, 32'd7, 1, 1'b0);

    // start and cancel together in IDLE: nothing accepted.
    dividend = 32'd9; divisor = 32'd5; start = 1'b1; cancel = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("start_cancel_ready", 32'(ready), 32'd0);
    end
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    run_div(1'b1, 32'h8000_0000, 32'd3, 1, 1'b0);

    run_div(1'b0, 32'd50, 32'd7, 0, 1'b1);
    run_div(1'b1, 32'd17, 32'hFFFF_FFFB, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      cls = $urandom_range(0, 7);
      a   = (cls[0]) ? Word_t'($urandom_range(0, 255)) : Word_t'($urandom);
      case (cls)
        0:       b = 32'd0;
        1:       b = (a[3]) ? 32'd1 : 32'hFFFF_FFFF;
        2, 3:    b = Word_t'($urandom_range(1, 15));
        default: b = Word_t'($urandom);
      endcase
      if (cls == 4) a = 32'h8000_0000;
      run_div(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
